// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding, BCD constants
// and the power-of-ten helper used to size the representable range.
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift,
// so that the shift carries it correctly into the next decimal position.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Operands above the decimal range saturate to all nines and raise overflow.
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam int          SCR_W   = 4 * DIGITS + BIN_W;
  localparam int          CNT_W   = $clog2(BIN_W + 1);

  state_t             state;
  state_t             state_nx;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_nx;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_l;
  logic               ovf_in;
  logic               last;

  // Upper 4*DIGITS bits of the scratch register are the BCD accumulator.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[BIN_W + 4*i +: 4]),
      .adj   (scratch_adj[BIN_W + 4*i +: 4])
    );
  end

  assign scratch_adj[BIN_W-1:0] = scratch[BIN_W-1:0];
  assign scratch_nx             = {scratch_adj[SCR_W-2:0], 1'b0};
  assign last                   = (cnt == CNT_W'(1));
  assign ovf_in                 = (32'(bin_in) > MAX_VAL);
  assign busy                   = (state == ST_SHIFT);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (last)  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch  <= '0;
      cnt      <= '0;
      ovf_l    <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          scratch <= {{(4*DIGITS){1'b0}}, bin_in};
          cnt     <= CNT_W'(BIN_W);
          ovf_l   <= ovf_in;
        end
      end else begin
        scratch <= scratch_nx;
        cnt     <= cnt - CNT_W'(1);
        if (last) begin
          done     <= 1'b1;
          overflow <= ovf_l;
          bcd_out  <= ovf_l ? {DIGITS{BCD_NINE}} : scratch_nx[SCR_W-1:BIN_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Bench for bin_to_bcd_converter: directed handshake/boundary steps followed by a
// randomized sweep compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_converter #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'h9999;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a conversion, optionally poking start again at busy-cycle inj, and return
  // the number of edges from the start edge to the edge that raised done.
  task automatic run_conv(input int v, input int inj, output int lat);
    logic [15:0] prev;
    prev   = bcd_out;
    start  = 1'b1;
    bin_in = 14'(v);
    step();
    start  = 1'b0;
    lat    = 0;
    while (done !== 1'b1 && lat < 40) begin
      check("busy_high", busy, 1);
      check("bcd_hold", bcd_out, prev);
      if (inj != 0 && lat + 1 == inj) begin
        start  = 1'b1;
        bin_in = 14'd42;
      end
      step();
      start  = 1'b0;
      bin_in = 14'($urandom);
      lat++;
    end
    check("done_seen", done, 1);
    check("busy_low_at_done", busy, 0);
  endtask

  initial begin
    int lat;
    int v;
    logic saw_done;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Zero operand
    run_conv(0, 0, lat);
    check("zero_lat", lat, 14);
    check("zero_bcd", bcd_out, 16'h0000);
    check("zero_ovf", overflow, 0);
    step();

    // 1234, done must be a single-cycle pulse
    run_conv(1234, 0, lat);
    check("1234_lat", lat, 14);
    check("1234_bcd", bcd_out, 16'h1234);
    step();
    check("done_pulse_width", done, 0);
    check("1234_bcd_held", bcd_out, 16'h1234);

    // Range boundaries
    run_conv(9999, 0, lat);
    check("9999_bcd", bcd_out, 16'h9999);
    check("9999_ovf", overflow, 0);
    run_conv(10000, 0, lat);
    check("10000_lat", lat, 14);
    check("10000_bcd", bcd_out, 16'h9999);
    check("10000_ovf", overflow, 1);
    run_conv(16383, 0, lat);
    check("16383_bcd", bcd_out, 16'h9999);
    check("16383_ovf", overflow, 1);
    run_conv(5, 0, lat);
    check("ovf_clears", overflow, 0);

    // start while busy is ignored; start in the done cycle is accepted
    run_conv(777, 5, lat);
    check("777_lat", lat, 14);
    check("777_bcd", bcd_out, 16'h0777);
    run_conv(42, 0, lat);
    check("b2b_gap", lat + 1, 15);
    check("b2b_bcd", bcd_out, 16'h0042);

    // Reset mid-conversion
    start  = 1'b1;
    bin_in = 14'd3000;
    step();
    start  = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_bcd", bcd_out, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    run_conv(5, 0, lat);
    check("after_rst_lat", lat, 14);
    check("after_rst_bcd", bcd_out, 16'h0005);

    // Random sweep
    for (int n = 0; n < 1000; n++) begin
      v = int'($urandom_range(0, 16383));
      run_conv(v, 0, lat);
      check("rnd_lat", lat, 14);
      check("rnd_bcd", bcd_out, ref_bcd(v));
      check("rnd_ovf", overflow, (v > 9999) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
